// File: rtl/seq_stream_pkg.sv
// Types shared by the serial stream feeding seq_detector.
package seq_stream_pkg;

  localparam int SER_WIDTH_DEFAULT = 32;
  localparam int SER_LEN_W_DEFAULT = $clog2(SER_WIDTH_DEFAULT + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic [SER_WIDTH_DEFAULT-1:0] data;
    logic [SER_LEN_W_DEFAULT-1:0] len;
  } ser_word_t;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter; a one-word holding register lets
// consecutive words stream with no idle cycle between them.
module bit_serializer
  import seq_stream_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [LEN_W-1:0] s_len,
  input  logic             stall,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy,
  output logic             err_len
);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  ser_word_t        hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             err_len_q, err_len_d;

  ser_word_t        in_word_s;
  ser_word_t        load_word_s;
  logic             accept_s;
  logic             legal_s;
  logic             load_s;
  logic             step_s;
  logic             advance_s;

  // Left-align a word so its first bit sits at the shifter MSB; bits at and
  // above len fall off the top.
  function automatic logic [WIDTH-1:0] align_word(input ser_word_t w);
    logic [WIDTH-1:0] d;
    logic [LEN_W-1:0] l;
    d = WIDTH'(w.data);
    l = LEN_W'(w.len);
    return d << (LEN_W'(WIDTH) - l);
  endfunction

  assign s_ready   = !hold_full_q && !reset;
  assign accept_s  = s_valid && s_ready;
  assign legal_s   = (s_len != {LEN_W{1'b0}}) && (s_len <= LEN_W'(WIDTH));
  assign in_word_s = '{data: SER_WIDTH_DEFAULT'(s_data), len: SER_LEN_W_DEFAULT'(s_len)};

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign err_len   = err_len_q;

  // State register: shifter holds the bit on display at its MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= {WIDTH{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      hold_q      <= {$bits(ser_word_t){1'b0}};
      hold_full_q <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      err_len_q   <= err_len_d;
    end
  end

  // Next state: load, step or park the shifter and fill/drain the holding slot.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_s      = 1'b0;
    step_s      = 1'b0;
    load_word_s = in_word_s;
    case (state_q)
      IDLE: begin
        if (accept_s && legal_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      SHIFT: begin
        if (stall || (cnt_q != LEN_W'(1))) begin
          step_s = !stall;
          if (accept_s && legal_s) begin
            hold_d      = in_word_s;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end else if (hold_full_q) begin
          load_s      = 1'b1;
          load_word_s = hold_q;
          hold_full_d = 1'b0;
        end else if (accept_s && legal_s) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      state_d = SHIFT;
      shift_d = align_word(load_word_s);
      cnt_d   = LEN_W'(load_word_s.len);
    end else if (step_s) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - LEN_W'(1);
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
    advance_s = load_s || step_s;
  end

  // Output decode from next state; a frozen shifter keeps its MSB on out.
  always_comb begin
    out_valid_d = advance_s;
    out_d       = (state_d == SHIFT) ? shift_d[WIDTH-1] : 1'b0;
    last_d      = (state_d == SHIFT) && (cnt_d == LEN_W'(1));
    busy_d      = (state_d == SHIFT) || hold_full_d;
    err_len_d   = accept_s && !legal_s;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios plus randomized
// traffic compared against a word-level bit-queue model.
module tb_bit_serializer;

  localparam int WIDTH = 32;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [LEN_W-1:0] s_len;
  logic             stall;
  logic             out;
  logic             out_valid;
  logic             last;
  logic             busy;
  logic             err_len;

  int total = 0;
  int bad   = 0;
  int err_exp = 0;

  logic tr_v[$], tr_o[$], tr_l[$], tr_b[$], tr_e[$], tr_r[$];
  logic exp_bits[$], exp_last[$];
  logic got_bits[$], got_last[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_len(s_len), .stall(stall), .out(out),
    .out_valid(out_valid), .last(last), .busy(busy), .err_len(err_len)
  );

  // Per-cycle trace taken mid-cycle.
  always @(negedge clk) begin
    tr_v.push_back(out_valid); tr_o.push_back(out); tr_l.push_back(last);
    tr_b.push_back(busy); tr_e.push_back(err_len); tr_r.push_back(s_ready);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_trace();
    tr_v.delete(); tr_o.delete(); tr_l.delete();
    tr_b.delete(); tr_e.delete(); tr_r.delete();
  endtask

  task automatic extract_stream();
    got_bits.delete(); got_last.delete();
    for (int i = 0; i < tr_v.size(); i++)
      if (tr_v[i] === 1'b1) begin got_bits.push_back(tr_o[i]); got_last.push_back(tr_l[i]); end
  endtask

  // Reference: a legal word contributes its low len bits, MSB first.
  task automatic model_word(input logic [WIDTH-1:0] d, input int len);
    if (len < 1 || len > WIDTH) err_exp++;
    else for (int i = len - 1; i >= 0; i--) begin
      exp_bits.push_back(d[i]); exp_last.push_back(i == 0);
    end
  endtask

  function automatic int det_count(input logic q[$]);
    int n = 0;
    for (int i = 0; i + 4 < q.size(); i++)
      if ({q[i], q[i+1], q[i+2], q[i+3], q[i+4]} == 5'b11011) n++;
    return n;
  endfunction

  task automatic send_word(input logic [WIDTH-1:0] d, input int len);
    logic r;
    bit ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_len = LEN_W'(len);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); r = s_ready;
      @(posedge clk); #1;
      if (r === 1'b1) ok = 1'b1;
    end
    s_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL send_timeout: got no accept, want accept within 100 cycles"); end
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out !== 1'b0) begin bad++; $display("FAIL rst_out: got %b want 0", out); end
    total++; if (last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL rst_err_len: got %b want 0", err_len); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset: got %b want 0", s_ready); end
    reset = 1'b0;
    tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", s_ready); end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] d;
    d = $urandom(); d[4:0] = 5'b11011;
    exp_bits.delete(); exp_last.delete(); model_word(d, 5);
    send_word(d, 5);
    clear_trace();
    repeat (7) tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (tr_v[i] !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: got %b want 1", i, tr_v[i]); end
      total++; if (tr_o[i] !== exp_bits[i]) begin bad++; $display("FAIL single_bit[%0d]: got %b want %b", i, tr_o[i], exp_bits[i]); end
      total++; if (tr_l[i] !== exp_last[i]) begin bad++; $display("FAIL single_last[%0d]: got %b want %b", i, tr_l[i], exp_last[i]); end
    end
    total++; if (tr_v[5] !== 1'b0 || tr_b[5] !== 1'b0) begin bad++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", tr_v[5], tr_b[5]); end
    extract_stream();
    total++; if (det_count(got_bits) != det_count(exp_bits)) begin bad++; $display("FAIL single_detect: got %0d want %0d", det_count(got_bits), det_count(exp_bits)); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d1, d2;
    int nv = 0;
    d1 = $urandom(); d1[7:0] = 8'b11011011;
    d2 = $urandom(); d2[4:0] = 5'b11101;
    exp_bits.delete(); exp_last.delete(); model_word(d1, 8); model_word(d2, 5);
    send_word(d1, 8);
    clear_trace();
    send_word(d2, 5);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_held: got %b want 0", s_ready); end
    repeat (15) tick();
    for (int i = 0; i < tr_v.size(); i++) if (tr_v[i] === 1'b1) nv++;
    total++; if (nv != 13) begin bad++; $display("FAIL b2b_count: got %0d want 13", nv); end
    for (int i = 0; i < 13; i++) begin
      total++; if (tr_v[i] !== 1'b1 || tr_o[i] !== exp_bits[i] || tr_l[i] !== exp_last[i]) begin
        bad++; $display("FAIL b2b_bit[%0d]: got v=%b o=%b l=%b want 1 %b %b", i, tr_v[i], tr_o[i], tr_l[i], exp_bits[i], exp_last[i]);
      end
    end
    total++; if (tr_r[1] !== 1'b0 || tr_r[7] !== 1'b0) begin bad++; $display("FAIL b2b_ready_low: got %b %b want 0 0", tr_r[1], tr_r[7]); end
    total++; if (tr_r[8] !== 1'b1) begin bad++; $display("FAIL b2b_ready_back: got %b want 1", tr_r[8]); end
    extract_stream();
    total++; if (det_count(got_bits) != det_count(exp_bits)) begin bad++; $display("FAIL b2b_detect: got %0d want %0d", det_count(got_bits), det_count(exp_bits)); end
  endtask

  task automatic test_illegal();
    int ne = 0;
    clear_trace();
    err_exp = 0;
    model_word(WIDTH'($urandom()), 0);
    send_word(WIDTH'($urandom()), 0);
    tick(); tick();
    model_word(WIDTH'($urandom()), 33);
    send_word(WIDTH'($urandom()), 33);
    repeat (3) tick();
    total++; if (tr_e[0] !== 1'b0 || tr_e[1] !== 1'b1) begin bad++; $display("FAIL illegal_pulse_time: got %b%b want 01", tr_e[0], tr_e[1]); end
    for (int i = 0; i < tr_e.size(); i++) begin
      if (tr_e[i] === 1'b1) ne++;
      total++; if (tr_v[i] !== 1'b0 || tr_b[i] !== 1'b0) begin bad++; $display("FAIL illegal_quiet[%0d]: got valid=%b busy=%b want 0 0", i, tr_v[i], tr_b[i]); end
    end
    total++; if (ne != err_exp) begin bad++; $display("FAIL illegal_err_count: got %0d want %0d", ne, err_exp); end
  endtask

  task automatic test_stall();
    logic [6:0] v_tab, o_tab, l_tab;
    int first = -1, lastv = -1;
    v_tab = 7'b0110011; o_tab = 7'b0010001; l_tab = 7'b0100000;
    send_word(WIDTH'(4'b1010), 4);
    clear_trace();
    tick(); stall = 1'b1;
    tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stall_ready: got %b want 1", s_ready); end
    tick(); stall = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      total++; if (tr_v[i] !== v_tab[i] || tr_o[i] !== o_tab[i] || tr_l[i] !== l_tab[i]) begin
        bad++; $display("FAIL stall_cycle[%0d]: got v=%b o=%b l=%b want %b %b %b", i, tr_v[i], tr_o[i], tr_l[i], v_tab[i], o_tab[i], l_tab[i]);
      end
      if (tr_v[i] === 1'b1) begin if (first < 0) first = i; lastv = i; end
    end
    total++; if (lastv - first + 1 != 6) begin bad++; $display("FAIL stall_span: got %0d want 6", lastv - first + 1); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d1, d3;
    d1 = $urandom(); d1[7:0] = 8'b10101010;
    exp_bits.delete(); exp_last.delete(); model_word(d1, 8);
    send_word(d1, 8);
    clear_trace();
    send_word(WIDTH'($urandom()), 6);
    tick(); reset = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got valid=%b busy=%b want 0 0", out_valid, busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_reset: got %b want 0", s_ready); end
    reset = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (tr_v[i] !== 1'b1 || tr_o[i] !== exp_bits[i]) begin bad++; $display("FAIL rmid_prefix[%0d]: got v=%b o=%b want 1 %b", i, tr_v[i], tr_o[i], exp_bits[i]); end
    end
    for (int i = 3; i < tr_v.size(); i++) begin
      total++; if (tr_v[i] !== 1'b0 || tr_b[i] !== 1'b0) begin bad++; $display("FAIL rmid_flushed[%0d]: got valid=%b busy=%b want 0 0", i, tr_v[i], tr_b[i]); end
    end
    d3 = $urandom(); d3[4:0] = 5'b11011;
    exp_bits.delete(); exp_last.delete(); model_word(d3, 5);
    send_word(d3, 5);
    clear_trace();
    repeat (7) tick();
    extract_stream();
    total++; if (got_bits.size() != 5) begin bad++; $display("FAIL rmid_fresh_len: got %0d want 5", got_bits.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (got_bits[i] !== exp_bits[i]) begin bad++; $display("FAIL rmid_fresh_bit[%0d]: got %b want %b", i, got_bits[i], exp_bits[i]); end
    end
    total++; if (det_count(got_bits) != det_count(exp_bits)) begin bad++; $display("FAIL rmid_detect: got %0d want %0d", det_count(got_bits), det_count(exp_bits)); end
  endtask

  task automatic test_random();
    localparam int NW = 40;
    int sent = 0, ne = 0, len = 0;
    logic have = 1'b0;
    logic r;
    logic [WIDTH-1:0] d = '0;
    clear_trace();
    exp_bits.delete(); exp_last.delete(); err_exp = 0;
    for (int c = 0; c < 6000 && sent < NW; c++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        d = $urandom();
        if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63);
        else len = $urandom_range(1, WIDTH);
        s_valid = 1'b1; s_data = d; s_len = LEN_W'(len); have = 1'b1;
      end
      stall = ($urandom_range(0, 3) == 0);
      @(negedge clk); r = s_ready;
      @(posedge clk); #1;
      if (have && r === 1'b1) begin
        model_word(d, len);
        s_valid = 1'b0; have = 1'b0; sent++;
      end
    end
    stall = 1'b0; s_valid = 1'b0;
    total++; if (sent != NW) begin bad++; $display("FAIL rand_timeout: got %0d words want %0d", sent, NW); end
    repeat (80) tick();
    extract_stream();
    total++; if (got_bits.size() != exp_bits.size()) begin bad++; $display("FAIL rand_bit_count: got %0d want %0d", got_bits.size(), exp_bits.size()); end
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++) begin
      total++; if (got_bits[i] !== exp_bits[i] || got_last[i] !== exp_last[i]) begin
        bad++; $display("FAIL rand_bit[%0d]: got o=%b l=%b want %b %b", i, got_bits[i], got_last[i], exp_bits[i], exp_last[i]);
      end
    end
    for (int i = 0; i < tr_e.size(); i++) if (tr_e[i] === 1'b1) ne++;
    total++; if (ne != err_exp) begin bad++; $display("FAIL rand_err_count: got %0d want %0d", ne, err_exp); end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_len = '0; stall = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
